mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//   Initiator side of the data-memory port: turns datapath load/store requests (RV32 lb/lh/lw/lbu/lhu, sb/sh/sw)
//   into word-wide memRead/memWrite cycles on the 32-word data memory. Sub-word stores use read-modify-write.
//   Sits between the execute stage and the data memory, and returns aligned, sign/zero-extended load data.
// PARAMETERS
//   MEM_WORDS  32  number of 32-bit words in the data memory
//   WIDX_W     5   word-index width, log2(MEM_WORDS)
// PORTS
//   clk            in   1   single clock, all state updates on rising edge
//   reset          in   1   synchronous, active-high
//   req_valid      in   1   request present
//   req_ready      out  1   high only in IDLE; a request is accepted on an edge with req_valid & req_ready
//   req_write      in   1   1 = store, 0 = load
//   req_funct3     in   3   000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 only (stores)
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data; low byte/half used for sb/sh
//   resp_valid     out  1   one-cycle pulse, request complete
//   resp_rdata     out  32  load result (0 for stores and errors)
//   resp_error     out  1   valid with resp_valid: misaligned, illegal funct3 or out-of-range address
//   memRead        out  1   read strobe to data memory
//   memWrite       out  1   write strobe to data memory
//   address        out  32  word index, zero-extended {0, req_addr[WIDX_W+1:2]}
//   writeData      out  32  word written
//   readData       in   32  word read
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, memRead=0, memWrite=0, address=0, writeData=0.
//   - Request fields latched at acceptance; inputs ignored until return to IDLE. No response backpressure.
//   - FSM: IDLE, RD, RD_CAP, WR, RESP. Outputs registered/decoded from state and latched fields only.
//     IDLE->RESP on error; IDLE->WR on sw; IDLE->RD on any load, sb, sh.
//     RD: memRead=1. RD->RD_CAP. RD_CAP: memRead=1, readData captured at end of cycle.
//     RD_CAP->RESP (load) or ->WR (sb/sh). WR: memWrite=1 for exactly one cycle, writeData stable. WR->RESP.
//     RESP: resp_valid=1 one cycle -> IDLE. memRead/memWrite never both high.
//   - Latency (acceptance edge to resp_valid cycle): error 1, sw 2, load 3, sb/sh 4.
//   - Errors (no memory strobe issued): lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0;
//     funct3 011/110/111; store funct3 1xx; addr[31:WIDX_W+2] != 0.
//   - Little-endian lanes: byte k = bits [8k+7:8k], k=addr[1:0]; half at addr[1] selects [31:16] vs [15:0].
//   - Loads: lb/lh sign-extend, lbu/lhu zero-extend, lw passes word through.
//   - sb/sh merge: captured word with selected lane replaced by req_wdata[7:0]/[15:0]; other lanes unchanged.
//   - address held constant from RD through WR of one request.
//   - resp_rdata/resp_error hold their last value after RESP until the next RESP; they are valid only with resp_valid.
//   - Reset mid-operation: IDLE on next edge; strobes drop; an RMW reset before WR writes nothing; no resp_valid.
// STRUCTURE
//   - Shared package mem_access_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding,
//     MEM_WORDS default.
//   - One combinational sub-module lane_align: load extract+extend and store merge from (word, addr[1:0], funct3).
//   - Top holds FSM, request latch, captured read word, strobe/address registers.
// TESTING (bench instantiates this block against the team's dataMemory model)
//   1. sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> memWrite 1 cycle at word 4; lw resp 3 cycles later, rdata 0xDEADBEEF.
//   2. After 1: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
//   3. sb 0x11 data 0x55 on word 0xDEADBEEF -> RD,RD_CAP,WR,RESP; word 4 = 0xDEAD55EF; sh 0x12 0x1234 -> 0x123455EF.
//   4. lw 0x02, sh 0x05, lb addr 0x80, funct3 011 -> resp_error=1 one cycle after accept, memRead/memWrite never high.
//   5. reset asserted in RD_CAP of sb 0x00 -> next cycle IDLE, no memWrite, word 0 unchanged, no resp_valid.
//   6. req_valid held high back-to-back lw/sw: req_ready low while busy; each request answered exactly once, in order.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access controller: funct3 codes,
// FSM state encoding and default memory geometry.
package mem_access_pkg;

   localparam int DEF_MEM_WORDS = 32;
   localparam int DEF_WIDX_W    = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_RD_CAP = 3'd2,
      ST_WR     = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into a memory word (little-endian lanes).
module lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_load_data = i_word;
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_load_data = {24'h0, w_byte};
         F3_HU:   o_load_data = {16'h0, w_half};
         default: o_load_data = i_word;
      endcase
   end

   // Unselected lanes keep the word captured from memory.
   always_comb begin
      o_store_word = i_word;
      case (i_funct3)
         F3_B:    o_store_word[{i_off, 3'b000} +: 8]  = i_wdata[7:0];
         F3_H:    o_store_word[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
         default: o_store_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: turns RV32 load/store requests into word-wide
// memRead/memWrite cycles, with read-modify-write for sub-word stores.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int MEM_WORDS = DEF_MEM_WORDS,
   parameter int WIDX_W    = DEF_WIDX_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] address,
   output logic [31:0] writeData,
   input  logic [31:0] readData,
   output logic [2:0]  o_dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE. resp_valid is a
   // single-cycle pulse with no backpressure.

   state_t      r_state;
   state_t      w_next_state;
   logic        r_write;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [31:0] r_address;
   logic [31:0] r_write_data;
   logic [31:0] r_resp_rdata;
   logic        r_resp_error;

   logic        w_accept;
   logic        w_f3_bad;
   logic        w_misalign;
   logic        w_out_range;
   logic        w_err;
   logic        w_is_sw;
   logic [31:0] w_load_data;
   logic [31:0] w_store_word;

   assign w_accept = req_valid && (r_state == ST_IDLE);
   assign w_is_sw  = req_write && (req_funct3 == F3_W);

   always_comb begin
      w_f3_bad    = 1'b0;
      w_misalign  = 1'b0;
      case (req_funct3)
         F3_B, F3_H, F3_W: w_f3_bad = 1'b0;
         F3_BU, F3_HU:     w_f3_bad = req_write;
         default:          w_f3_bad = 1'b1;
      endcase
      case (req_funct3[1:0])
         2'b01:   w_misalign = req_addr[0];
         2'b10:   w_misalign = |req_addr[1:0];
         default: w_misalign = 1'b0;
      endcase
      w_out_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
      w_err       = w_f3_bad || w_misalign || w_out_range;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err)        w_next_state = ST_RESP;
               else if (w_is_sw) w_next_state = ST_WR;
               else              w_next_state = ST_RD;
            end
         end
         ST_RD:     w_next_state = ST_RD_CAP;
         ST_RD_CAP: w_next_state = r_write ? ST_WR : ST_RESP;
         ST_WR:     w_next_state = ST_RESP;
         ST_RESP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   lane_align u_lane_align (
      .i_word       (readData),
      .i_wdata      (r_wdata),
      .i_off        (r_off),
      .i_funct3     (r_funct3),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_write      <= 1'b0;
         r_funct3     <= 3'b000;
         r_off        <= 2'b00;
         r_wdata      <= 32'h0;
         r_address    <= 32'h0;
         r_write_data <= 32'h0;
         r_resp_rdata <= 32'h0;
         r_resp_error <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
            if (w_err) begin
               r_resp_error <= 1'b1;
               r_resp_rdata <= 32'h0;
            end else begin
               r_address <= {{(32-WIDX_W){1'b0}}, req_addr[WIDX_W+1:2]};
               if (w_is_sw) r_write_data <= req_wdata;
            end
         end
         // The read word is consumed on the edge that leaves RD_CAP.
         if (r_state == ST_RD_CAP) begin
            if (r_write) begin
               r_write_data <= w_store_word;
            end else begin
               r_resp_rdata <= w_load_data;
               r_resp_error <= 1'b0;
            end
         end
         if (r_state == ST_WR) begin
            r_resp_rdata <= 32'h0;
            r_resp_error <= 1'b0;
         end
      end
   end

   assign req_ready   = (r_state == ST_IDLE);
   assign memRead     = (r_state == ST_RD) || (r_state == ST_RD_CAP);
   assign memWrite    = (r_state == ST_WR);
   assign resp_valid  = (r_state == ST_RESP);
   assign resp_rdata  = r_resp_rdata;
   assign resp_error  = r_resp_error;
   assign address     = r_address;
   assign writeData   = r_write_data;
   assign o_dbg_state = r_state;

endmodule
